// File: rtl/div64_seq_if.sv
// Start/result handshake bundle for the 64-bit sequential divider.
// master: ALU control side (drives the request, observes the results).
// slave : divider side (samples the request, drives busy/done/results/flags).
interface div64_seq_if;
  localparam int unsigned W = 64;

  logic         start;
  logic         op_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  modport master (
    output start, op_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, op_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/div64_seq.sv
// Sequential 64-bit restoring divider, one quotient bit per cycle.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - div64_seq_if.slave: start/op_signed/dividend/divisor in,
//           busy/done/quotient/remainder/div_by_zero/overflow out (all registered)
// Signed mode truncates toward zero; the remainder takes the dividend's sign.
module div64_seq (
  input  logic         clk,
  input  logic         reset,
  div64_seq_if.slave   bus
);
  localparam int unsigned W  = 64;
  localparam int unsigned CW = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic           sgn_q, sgn_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W:0]     r_q, r_d;
  logic [W-1:0]   q_q, q_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q_q, neg_q_d;
  logic           neg_r_q, neg_r_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;
  logic           ovf_q, ovf_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [W:0]     r_sh;
  logic [W:0]     trial;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    // R never exceeds the divisor magnitude, so its MSB is always 0 before the
    // shift; the truncating cast drops it.
    r_sh  = (W+1)'({r_q, q_q[W-1]});
    trial = r_sh + ~{1'b0, b_q} + (W+1)'(1);
    a_mag = (sgn_q && a_q[W-1]) ? (~a_q + W'(1)) : a_q;
    b_mag = (sgn_q && b_q[W-1]) ? (~b_q + W'(1)) : b_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sgn_d   = bus.op_signed;
          a_d     = bus.dividend;
          b_d     = bus.divisor;
          state_d = S_PREP;
        end
      end

      S_PREP: begin
        if (b_q == '0) begin
          quo_d   = '1;
          rem_d   = a_q;
          dbz_d   = 1'b1;
          ovf_d   = 1'b0;
          state_d = S_DONE;
        end else if (sgn_q && (a_q == {1'b1, {(W-1){1'b0}}}) && (b_q == '1)) begin
          quo_d   = {1'b1, {(W-1){1'b0}}};
          rem_d   = '0;
          dbz_d   = 1'b0;
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          q_d     = a_mag;
          b_d     = b_mag;
          neg_q_d = sgn_q & (a_q[W-1] ^ b_q[W-1]);
          neg_r_d = sgn_q & a_q[W-1];
          r_d     = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // Restore on a negative trial (bit W set); otherwise keep the difference.
        q_d = {q_q[W-2:0], ~trial[W]};
        r_d = trial[W] ? r_sh : trial;
        if (cnt_q == CW'(W-1)) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_FIX: begin
        quo_d   = neg_q_q ? (~q_q + W'(1)) : q_q;
        rem_d   = neg_r_q ? (~r_q[W-1:0] + W'(1)) : r_q[W-1:0];
        dbz_d   = 1'b0;
        ovf_d   = 1'b0;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_PREP) || (state_d == S_RUN) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule
